// File: rtl/regfile_wb_scheduler.sv
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Shares the single register-file write port between the ALU (A)
//            and memory/load (M) writeback requesters. It also keeps a
//            per-register pending-write scoreboard that decode uses to detect
//            RAW/WAW hazards.
// Options  : WB_FIXED_PRIO_EN - when defined, M always beats A and no
//            last-grant state is kept. The default build uses round-robin.
// Ports    : clk, rst                       clock, synchronous active-high reset
//            a_valid_i/a_ready_o/a_addr_i/a_data_i   requester A handshake
//            m_valid_i/m_ready_o/m_addr_i/m_data_i   requester M handshake
//            iss_valid_i/iss_addr_i/iss_ready_o      decode destination issue
//            rs_addr_i/rt_addr_i/rs_busy_o/rt_busy_o source hazard queries
//            wr_en_o/wr_addr_o/wr_data_o             register-file write port
//            busy_vec_o                              scoreboard contents
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              m_valid_i,
  output logic              m_ready_o,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [DATA_W-1:0] m_data_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  output logic              iss_ready_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [NREG-1:0]   busy_vec_o
);

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic              w_grant_a;
  logic              w_grant_m;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

`ifdef WB_FIXED_PRIO_EN
  // M always wins; A only proceeds when M is idle.
  always_comb begin
    w_grant_m = m_valid_i;
    w_grant_a = a_valid_i && !m_valid_i;
  end
`else
  // 1 = M was granted most recently. The reset value is A, so M wins the
  // first tie.
  logic last_grant_m_q;

  // On a tie, grant whichever requester was not granted last.
  always_comb begin
    w_grant_m = m_valid_i && (!a_valid_i || !last_grant_m_q);
    w_grant_a = a_valid_i && (!m_valid_i ||  last_grant_m_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_m_q <= 1'b0;
    end else if (w_grant_a || w_grant_m) begin
      last_grant_m_q <= w_grant_m;
    end
  end
`endif

  assign a_ready_o  = w_grant_a;
  assign m_ready_o  = w_grant_m;
  assign w_xfer     = w_grant_a || w_grant_m;
  assign w_sel_addr = w_grant_m ? m_addr_i : a_addr_i;
  assign w_sel_data = w_grant_m ? m_data_i : a_data_i;

  // Register 0 is hard-wired, so its entry is never set. That makes issues
  // to address 0 always ready, and source queries of address 0 read 0.
  assign iss_ready_o = !busy_q[iss_addr_i];
  assign rs_busy_o   = busy_q[rs_addr_i];
  assign rt_busy_o   = busy_q[rt_addr_i];

  // The clear happens on the commit edge, so decode keeps seeing busy until
  // the register file actually holds the value. A same-address clear and set
  // cannot coincide, because the issue is stalled while the bit is set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (iss_valid_i && iss_ready_o && (iss_addr_i != '0)) begin
      busy_d[iss_addr_i] = 1'b1;
    end
  end

  // Registered output stage. A handshake to register 0 completes but does
  // not assert the write enable, which discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        wr_addr_q <= w_sel_addr;
        wr_data_q <= w_sel_data;
      end
      busy_q <= busy_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_vec_o = busy_q;

endmodule

`default_nettype wire
